freq_peak_tracker: RTL and testbench

Parametrised successor of the single-channel resonance tracker in the SWIPT transmitter. It sweeps the drive frequency around a centre in N_STEPS points, samples the receiver envelope peak at each point and re-centres on the best point. It then shrinks the step until the step falls below MIN_DELTA, and then holds lock while monitoring the envelope. New over the previous generation: configurable sweep width and timing, frequency clamping, a lock-loss filter, a synchronous restart, a hold input, and status outputs.

---
 rtl/freq_peak_tracker_if.sv | 25 ++
 rtl/freq_peak_tracker.sv | 236 +++++++++++++++++++++++
 tb/tb_freq_peak_tracker.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/freq_peak_tracker_if.sv
// Control/status bundle between the SWIPT resonance tracker and its surroundings.
// The master side drives restart/hold/envelope; the slave side is the tracker.
interface freq_peak_tracker_if #(
    parameter int FREQ_W = 32,
    parameter int AMP_W  = 12
);
    logic                     i_restart;
    logic                     i_hold;
    logic signed [AMP_W-1:0]  i_envelope_max;
    logic [FREQ_W-1:0]        o_freq;
    logic                     o_enable;
    logic                     o_locked;
    logic [3:0]               o_level;
    logic signed [AMP_W-1:0]  o_peak_amp;

    modport master (
        output i_restart, i_hold, i_envelope_max,
        input  o_freq, o_enable, o_locked, o_level, o_peak_amp
    );

    modport slave (
        input  i_restart, i_hold, i_envelope_max,
        output o_freq, o_enable, o_locked, o_level, o_peak_amp
    );
endinterface

// File: rtl/freq_peak_tracker.sv
// Resonance tracker: sweeps N_STEPS points around a centre, re-centres on the
// strongest envelope, shrinks the step until lock, then watches for lock loss.
module freq_peak_tracker #(
    parameter int                FREQ_W     = 32,
    parameter int                AMP_W      = 12,
    parameter int                N_STEPS    = 7,
    parameter logic [FREQ_W-1:0] INIT_MID   = 1000,
    parameter logic [FREQ_W-1:0] INIT_DELTA = 300,
    parameter int                SHIFT      = 2,
    parameter logic [FREQ_W-1:0] MIN_DELTA  = 7,
    parameter logic [FREQ_W-1:0] F_MIN      = 1,
    parameter logic [FREQ_W-1:0] F_MAX      = '1,
    parameter int                SETTLE_CYC = 1200000,
    parameter int                OFF_CYC    = 400000,
    parameter int                HYST       = 100,
    parameter int                LOSS_CNT   = 4
) (
    input logic                 i_clk,
    input logic                 i_nrst,
    freq_peak_tracker_if.slave  bus
);
    localparam int HALF    = (N_STEPS - 1) / 2;
    localparam int IDX_W   = 5;
    localparam int FX_W    = FREQ_W + 2;
    localparam int AX_W    = AMP_W + 2;
    localparam int CNT_MAX = (SETTLE_CYC > OFF_CYC) ? SETTLE_CYC : OFF_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    localparam logic signed [IDX_W-1:0] IDX_LO      = IDX_W'(-HALF);
    localparam logic signed [IDX_W-1:0] IDX_HI      = IDX_W'(HALF);
    localparam logic signed [AMP_W-1:0] AMP_MIN     = {1'b1, {(AMP_W-1){1'b0}}};
    localparam logic signed [AX_W-1:0]  HYST_X      = AX_W'(HYST);
    localparam logic signed [FX_W-1:0]  FMIN_X      = {2'b00, F_MIN};
    localparam logic signed [FX_W-1:0]  FMAX_X      = {2'b00, F_MAX};
    localparam logic [CNT_W-1:0]        SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]        OFF_LAST    = CNT_W'(OFF_CYC - 1);
    localparam logic [MISS_W-1:0]       LOSS_LAST   = MISS_W'(LOSS_CNT - 1);

    typedef enum logic [3:0] {
        S_INIT, S_SET_FREQ, S_SETTLE, S_SAMPLE, S_OFF, S_DECIDE,
        S_LOCK_SET, S_LOCK_SETTLE, S_LOCK_MON
    } state_t;

    state_t                    r_state,     w_state_nxt;
    logic [FREQ_W-1:0]         r_mid,       w_mid_nxt;
    logic [FREQ_W-1:0]         r_delta,     w_delta_nxt;
    logic signed [IDX_W-1:0]   r_idx,       w_idx_nxt;
    logic signed [AMP_W-1:0]   r_ref,       w_ref_nxt;
    logic signed [AMP_W-1:0]   r_best,      w_best_nxt;
    logic [FREQ_W-1:0]         r_best_freq, w_best_freq_nxt;
    logic [CNT_W-1:0]          r_cnt,       w_cnt_nxt;
    logic [MISS_W-1:0]         r_miss,      w_miss_nxt;
    logic [FREQ_W-1:0]         r_freq,      w_freq_nxt;
    logic                      r_enable,    w_enable_nxt;
    logic                      r_locked,    w_locked_nxt;
    logic [3:0]                r_level,     w_level_nxt;
    logic signed [AMP_W-1:0]   r_peak,      w_peak_nxt;
    logic                      w_reload;

    logic signed [FX_W-1:0]    w_idx_x, w_cand;
    logic [FREQ_W-1:0]         w_cand_clamp, w_delta_sh;
    logic signed [AX_W-1:0]    w_best_x, w_ref_x, w_env_x;
    logic                      w_accept, w_out_win;

    assign w_idx_x      = {{(FX_W-IDX_W){r_idx[IDX_W-1]}}, r_idx};
    assign w_cand       = $signed({2'b00, r_mid}) + w_idx_x * $signed({2'b00, r_delta});
    assign w_cand_clamp = (w_cand < FMIN_X) ? F_MIN :
                          (w_cand > FMAX_X) ? F_MAX : w_cand[FREQ_W-1:0];
    assign w_delta_sh   = r_delta >> SHIFT;

    assign w_best_x  = {{2{r_best[AMP_W-1]}}, r_best};
    assign w_ref_x   = {{2{r_ref[AMP_W-1]}}, r_ref};
    assign w_env_x   = {{2{bus.i_envelope_max[AMP_W-1]}}, bus.i_envelope_max};
    // A level is kept unless the new peak fell more than HYST below the last one.
    assign w_accept  = (w_best_x + HYST_X) >= w_ref_x;
    assign w_out_win = (w_env_x < (w_ref_x - HYST_X)) || (w_env_x > (w_ref_x + HYST_X));

    always_comb begin
        w_state_nxt     = r_state;
        w_mid_nxt       = r_mid;
        w_delta_nxt     = r_delta;
        w_idx_nxt       = r_idx;
        w_ref_nxt       = r_ref;
        w_best_nxt      = r_best;
        w_best_freq_nxt = r_best_freq;
        w_cnt_nxt       = r_cnt;
        w_miss_nxt      = r_miss;
        w_freq_nxt      = r_freq;
        w_enable_nxt    = r_enable;
        w_locked_nxt    = r_locked;
        w_level_nxt     = r_level;
        w_peak_nxt      = r_peak;
        w_reload        = 1'b0;

        case (r_state)
            S_INIT: w_state_nxt = S_SET_FREQ;
            S_SET_FREQ: begin
                w_freq_nxt  = w_cand_clamp;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE, S_LOCK_SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_state == S_SETTLE) begin
                        w_state_nxt = S_SAMPLE;
                    end else begin
                        w_locked_nxt = 1'b1;
                        w_state_nxt  = S_LOCK_MON;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                // Strict compare: on ties the earlier (lower-index) point wins.
                if (bus.i_envelope_max > r_best) begin
                    w_best_nxt      = bus.i_envelope_max;
                    w_best_freq_nxt = r_freq;
                end
                w_enable_nxt = 1'b0;
                w_state_nxt  = S_OFF;
            end
            S_OFF: begin
                if (r_cnt == OFF_LAST) begin
                    w_cnt_nxt    = '0;
                    w_enable_nxt = 1'b1;
                    if (r_idx < IDX_HI) begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = S_SET_FREQ;
                    end else begin
                        w_state_nxt = S_DECIDE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DECIDE: begin
                w_best_nxt      = AMP_MIN;
                w_best_freq_nxt = INIT_MID;
                w_idx_nxt       = IDX_LO;
                if (w_accept) begin
                    w_mid_nxt   = r_best_freq;
                    w_delta_nxt = w_delta_sh;
                    w_ref_nxt   = r_best;
                    w_peak_nxt  = r_best;
                    w_level_nxt = (r_level == 4'hF) ? r_level : r_level + 4'd1;
                    w_state_nxt = (w_delta_sh < MIN_DELTA) ? S_LOCK_SET : S_SET_FREQ;
                end else begin
                    w_mid_nxt   = INIT_MID;
                    w_delta_nxt = INIT_DELTA;
                    w_ref_nxt   = '0;
                    w_level_nxt = '0;
                    w_state_nxt = S_SET_FREQ;
                end
            end
            S_LOCK_SET: begin
                w_freq_nxt  = r_mid;
                w_state_nxt = S_LOCK_SETTLE;
            end
            S_LOCK_MON: begin
                if (w_out_win) begin
                    if (r_miss == LOSS_LAST) begin
                        w_reload    = 1'b1;
                        w_state_nxt = S_SET_FREQ;
                    end else begin
                        w_miss_nxt = r_miss + MISS_W'(1);
                    end
                end else begin
                    w_miss_nxt = '0;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase

        // Lock loss re-acquires from scratch but leaves the drive frequency alone.
        if (w_reload || bus.i_restart) begin
            w_mid_nxt       = INIT_MID;
            w_delta_nxt     = INIT_DELTA;
            w_idx_nxt       = IDX_LO;
            w_ref_nxt       = '0;
            w_best_nxt      = AMP_MIN;
            w_best_freq_nxt = INIT_MID;
            w_cnt_nxt       = '0;
            w_miss_nxt      = '0;
            w_level_nxt     = '0;
            w_peak_nxt      = '0;
            w_locked_nxt    = 1'b0;
        end
        if (bus.i_restart) begin
            w_state_nxt  = S_INIT;
            w_freq_nxt   = INIT_MID;
            w_enable_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state     <= S_INIT;
            r_mid       <= INIT_MID;
            r_delta     <= INIT_DELTA;
            r_idx       <= IDX_LO;
            r_ref       <= '0;
            r_best      <= AMP_MIN;
            r_best_freq <= INIT_MID;
            r_cnt       <= '0;
            r_miss      <= '0;
            r_freq      <= INIT_MID;
            r_enable    <= 1'b1;
            r_locked    <= 1'b0;
            r_level     <= '0;
            r_peak      <= '0;
        end else if (bus.i_restart || !bus.i_hold) begin
            r_state     <= w_state_nxt;
            r_mid       <= w_mid_nxt;
            r_delta     <= w_delta_nxt;
            r_idx       <= w_idx_nxt;
            r_ref       <= w_ref_nxt;
            r_best      <= w_best_nxt;
            r_best_freq <= w_best_freq_nxt;
            r_cnt       <= w_cnt_nxt;
            r_miss      <= w_miss_nxt;
            r_freq      <= w_freq_nxt;
            r_enable    <= w_enable_nxt;
            r_locked    <= w_locked_nxt;
            r_level     <= w_level_nxt;
            r_peak      <= w_peak_nxt;
        end
    end

    assign bus.o_freq     = r_freq;
    assign bus.o_enable   = r_enable;
    assign bus.o_locked   = r_locked;
    assign bus.o_level    = r_level;
    assign bus.o_peak_amp = r_peak;
endmodule

// File: tb/tb_freq_peak_tracker.sv
// Bench for freq_peak_tracker: table of sweep points scored against a queue of
// expected frequencies, plus hand sequences for lock loss, hold and restart.
module tb_freq_peak_tracker;
    localparam int FREQ_W = 32;
    localparam int AMP_W  = 12;
    localparam int NROWS  = 45;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    freq_peak_tracker_if #(.FREQ_W(FREQ_W), .AMP_W(AMP_W)) bus();

    freq_peak_tracker #(
        .FREQ_W(FREQ_W), .AMP_W(AMP_W), .N_STEPS(5),
        .INIT_MID(1000), .INIT_DELTA(256), .SHIFT(2), .MIN_DELTA(7),
        .F_MIN(600), .SETTLE_CYC(4), .OFF_CYC(2), .HYST(100), .LOSS_CNT(4)
    ) dut (
        .i_clk(clk),
        .i_nrst(nrst),
        .bus(bus)
    );

    typedef struct {
        int env;        // envelope presented while this point is measured
        int exp_freq;   // frequency the tracker must be driving at the sample
        int exp_level;  // accepted levels at the time of the sample
        bit first;      // first point of a sweep (one extra cycle before it)
        int hold;       // cycles of i_hold inserted mid-settle
    } vec_t;

    vec_t vecs[NROWS];
    int   nrows = 0;
    int   total = 0;
    int   bad   = 0;
    int   sb_q[$];
    bit   sb_on = 1'b0;
    bit   prev_en = 1'b1;

    int s1[5] = '{600, 744, 1000, 1256, 1512};
    int s2[5] = '{872, 936, 1000, 1064, 1128};
    int s3[5] = '{1096, 1112, 1128, 1144, 1160};
    int t2[5] = '{600, 600, 600, 664, 728};
    int t3[5] = '{600, 600, 600, 616, 632};

    function automatic int model(input int f);
        int d;
        d = f - 1100;
        if (d < 0) d = -d;
        return 2000 - d;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input int f, input int env, input int lvl, input bit first, input int hold);
        vecs[nrows].exp_freq  = f;
        vecs[nrows].env       = env;
        vecs[nrows].exp_level = lvl;
        vecs[nrows].first     = first;
        vecs[nrows].hold      = hold;
        nrows++;
    endtask

    task automatic wait_en(input bit val, input int budget, inout int n);
        int k;
        k = 0;
        while (k < budget) begin
            @(negedge clk);
            n++;
            k++;
            if (bus.o_enable == val) return;
        end
        total++;
        bad++;
        $display("FAIL wait_enable=%0d: timed out after %0d cycles", val, budget);
    endtask

    task automatic wait_locked(inout int n);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n++;
            if (bus.o_locked) return;
        end
        total++;
        bad++;
        $display("FAIL wait_locked: timed out");
    endtask

    task automatic restart_pulse();
        bus.i_restart = 1'b1;
        @(negedge clk);
        bus.i_restart = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        int n;
        int m;
        sb_on = 1'b1;
        for (int i = lo; i <= hi; i++) begin
            bus.i_envelope_max = AMP_W'(vecs[i].env);
            sb_q.push_back(vecs[i].exp_freq);
            n = 0;
            if (vecs[i].hold > 0) begin
                repeat (3) begin @(negedge clk); n++; end
                bus.i_hold = 1'b1;
                repeat (vecs[i].hold) begin @(negedge clk); n++; end
                bus.i_hold = 1'b0;
            end
            wait_en(1'b0, 40, n);
            chk($sformatf("settle_len[%0d]", i), n, (vecs[i].first ? 7 : 6) + vecs[i].hold);
            chk($sformatf("level[%0d]", i), bus.o_level, vecs[i].exp_level);
            m = 0;
            wait_en(1'b1, 10, m);
            chk($sformatf("off_len[%0d]", i), m, 2);
        end
        sb_on = 1'b0;
        chk("sb_drain", sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Scoreboard: each falling o_enable marks a sample; o_freq must match the queue head.
    always @(negedge clk) begin
        if (sb_on && prev_en && !bus.o_enable) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_sample", bus.o_freq, -1);
            end else begin
                chk("sample_freq", bus.o_freq, sb_q.pop_front());
            end
        end
        prev_en = bus.o_enable;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.i_restart      = 1'b0;
        bus.i_hold         = 1'b0;
        bus.i_envelope_max = '0;

        // Acquisition, rejection (second sweep 300 low), tie on constant envelope.
        for (int k = 0; k < 5; k++) add(s1[k], model(s1[k]), 0, k == 0, 0);
        for (int k = 0; k < 5; k++) add(s2[k], model(s2[k]), 1, k == 0, 0);
        for (int k = 0; k < 5; k++) add(s3[k], model(s3[k]), 2, k == 0, 0);
        for (int k = 0; k < 5; k++) add(s1[k], model(s1[k]), 0, k == 0, (k == 1) ? 10 : 0);
        for (int k = 0; k < 5; k++) add(s2[k], model(s2[k]) - 300, 1, k == 0, 0);
        for (int k = 0; k < 5; k++) add(s1[k], model(s1[k]), 0, k == 0, 0);
        for (int k = 0; k < 5; k++) add(s1[k], 500, 0, k == 0, 0);
        for (int k = 0; k < 5; k++) add(t2[k], 500, 1, k == 0, 0);
        for (int k = 0; k < 5; k++) add(t3[k], 500, 2, k == 0, 0);

        repeat (3) @(negedge clk);
        chk("rst_freq", bus.o_freq, 1000);
        chk("rst_enable", bus.o_enable, 1);
        chk("rst_locked", bus.o_locked, 0);
        chk("rst_level", bus.o_level, 0);
        chk("rst_peak", bus.o_peak_amp, 0);
        nrst = 1'b1;

        run_rows(0, 14);
        bus.i_envelope_max = AMP_W'(model(1096));
        n = 0;
        wait_locked(n);
        chk("lock_latency", n, 6);
        chk("lock_freq", bus.o_freq, 1096);
        chk("lock_level", bus.o_level, 3);
        chk("lock_peak", bus.o_peak_amp, 1996);
        chk("lock_enable", bus.o_enable, 1);

        repeat (3) @(negedge clk);
        bus.i_envelope_max = AMP_W'(1800);
        repeat (3) @(negedge clk);
        chk("miss3_locked", bus.o_locked, 1);
        bus.i_envelope_max = AMP_W'(1996);
        repeat (2) @(negedge clk);
        chk("miss_cleared_locked", bus.o_locked, 1);
        bus.i_envelope_max = AMP_W'(1800);
        repeat (4) @(negedge clk);
        chk("loss_locked", bus.o_locked, 0);
        chk("loss_level", bus.o_level, 0);
        chk("loss_freq_kept", bus.o_freq, 1096);
        @(negedge clk);
        chk("loss_next_freq", bus.o_freq, 600);

        restart_pulse();
        run_rows(15, 29);

        restart_pulse();
        run_rows(30, 44);
        n = 0;
        wait_locked(n);
        chk("tie_lock_latency", n, 6);
        chk("tie_lock_freq", bus.o_freq, 600);
        chk("tie_lock_level", bus.o_level, 3);
        chk("tie_lock_peak", bus.o_peak_amp, 500);

        repeat (2) @(negedge clk);
        bus.i_hold    = 1'b1;
        bus.i_restart = 1'b1;
        @(negedge clk);
        chk("rsthold_freq", bus.o_freq, 1000);
        chk("rsthold_locked", bus.o_locked, 0);
        chk("rsthold_level", bus.o_level, 0);
        chk("rsthold_peak", bus.o_peak_amp, 0);
        bus.i_restart = 1'b0;
        bus.i_hold    = 1'b0;

        n = 0;
        wait_en(1'b0, 20, n);
        chk("pre_async_enable", bus.o_enable, 0);
        #2;
        nrst = 1'b0;
        #1;
        chk("async_rst_enable", bus.o_enable, 1);
        chk("async_rst_freq", bus.o_freq, 1000);
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
